// File: rtl/vga_pkg.sv
// Shared definitions for the VGA stream receiver: receiver states, colour and checksum
// widths, and the default frame geometry.
package vga_pkg;

  localparam int CHANW     = 4;
  localparam int COLRW     = 3 * CHANW;
  localparam int SUMW      = 16;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/vga_rx_if.sv
// Bundle of VGA stream inputs, probe request and receiver results.
// The master drives the stream; the receiver is the slave.
interface vga_rx_if #(
  parameter int CORDW = 16
);

  logic                     vga_hsync;
  logic                     vga_vsync;
  logic                     bright;
  logic [7:0]               vga_r;
  logic [7:0]               vga_g;
  logic [7:0]               vga_b;
  logic [CORDW-1:0]         probe_x;
  logic [CORDW-1:0]         probe_y;
  logic [CORDW-1:0]         rx_x;
  logic [CORDW-1:0]         rx_y;
  logic                     line_start;
  logic                     frame_start;
  logic                     locked;
  logic                     fmt_err;
  logic [vga_pkg::SUMW-1:0] frame_sum;
  logic                     frame_sum_valid;
  logic [vga_pkg::COLRW-1:0] probe_colr;
  logic                     probe_valid;
  logic [15:0]              frame_cnt;

  modport master (
    output vga_hsync, vga_vsync, bright, vga_r, vga_g, vga_b, probe_x, probe_y,
    input  rx_x, rx_y, line_start, frame_start, locked, fmt_err, frame_sum,
           frame_sum_valid, probe_colr, probe_valid, frame_cnt
  );

  modport slave (
    input  vga_hsync, vga_vsync, bright, vga_r, vga_g, vga_b, probe_x, probe_y,
    output rx_x, rx_y, line_start, frame_start, locked, fmt_err, frame_sum,
           frame_sum_valid, probe_colr, probe_valid, frame_cnt
  );

endinterface

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for an already-registered active-low sync signal.
// fall_o is high in the cycle where the sync reads 0 after having read 1.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= sync_i;
  end

  assign fall_o = prev_q & ~sync_i;

endmodule

// File: rtl/vga_rx.sv
// VGA stream receiver: measures line/frame geometry, checksums each frame, captures one
// probed pixel and tracks format lock through an ALIGN/SEARCH/LOCKED state machine.
module vga_rx
  import vga_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic    clk_25MHz,
  input  logic    btn_rst_n,
  vga_rx_if.slave vga
);

  localparam logic [CORDW-1:0] H_RES_C = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_RES_C = CORDW'(V_RES);

  logic             hs_q, vs_q, bright_q;
  logic [COLRW-1:0] colr_q;
  logic             hfall, vfall;
  logic             colr_lsb_unused;

  logic [CORDW-1:0] x_q, y_q, probe_x_q, probe_y_q;
  logic [SUMW-1:0]  sum_q;
  logic             bad_q, hit_q;
  logic [COLRW-1:0] hit_colr_q;
  rx_state_e        state_q;
  logic             good_q;

  logic             line_start_q, frame_start_q, locked_q, fmt_err_q;
  logic             sum_valid_q, probe_valid_q;
  logic [SUMW-1:0]  frame_sum_q;
  logic [15:0]      frame_cnt_q;
  logic [COLRW-1:0] probe_colr_q;

  logic             hit_now, line_done, sync_err, frame_bad, hit_d;
  logic [CORDW-1:0] x_d, y_close, y_d;
  logic [SUMW-1:0]  sum_d;
  logic             bad_d;
  logic [COLRW-1:0] hit_colr_d;

  assign colr_lsb_unused = ^{vga.vga_r[3:0], vga.vga_g[3:0], vga.vga_b[3:0]};

  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      bright_q <= 1'b0;
      colr_q   <= '0;
    end else begin
      hs_q     <= vga.vga_hsync;
      vs_q     <= vga.vga_vsync;
      bright_q <= vga.bright;
      colr_q   <= {vga.vga_r[7:4], vga.vga_g[7:4], vga.vga_b[7:4]};
    end
  end

  vga_sync_edge u_hs_edge (.clk(clk_25MHz), .rst_n(btn_rst_n), .sync_i(hs_q), .fall_o(hfall));
  vga_sync_edge u_vs_edge (.clk(clk_25MHz), .rst_n(btn_rst_n), .sync_i(vs_q), .fall_o(vfall));

  // Lines with no active pixels are blanking lines: they neither advance rx_y nor get length-checked.
  always_comb begin
    hit_now    = bright_q && (x_q == probe_x_q) && (y_q == probe_y_q);
    line_done  = hfall && (x_q != '0);
    sync_err   = bright_q && (!hs_q || !vs_q);
    x_d        = x_q;
    if (hfall)                      x_d = '0;
    else if (bright_q && x_q != '1) x_d = x_q + CORDW'(1);
    y_close    = line_done ? y_q + CORDW'(1) : y_q;
    y_d        = vfall ? '0 : y_close;
    sum_d      = bright_q ? sum_q + SUMW'(colr_q) : sum_q;
    bad_d      = bad_q | (line_done && (x_q != H_RES_C)) | sync_err;
    frame_bad  = bad_d | (y_close != V_RES_C);
    hit_d      = hit_q | hit_now;
    hit_colr_d = hit_now ? colr_q : hit_colr_q;
  end

  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      x_q <= '0; y_q <= '0; probe_x_q <= '0; probe_y_q <= '0;
      sum_q <= '0; bad_q <= 1'b0; hit_q <= 1'b0; hit_colr_q <= '0;
      state_q <= ST_ALIGN; good_q <= 1'b0;
      line_start_q <= 1'b0; frame_start_q <= 1'b0; locked_q <= 1'b0; fmt_err_q <= 1'b0;
      sum_valid_q <= 1'b0; probe_valid_q <= 1'b0;
      frame_sum_q <= '0; frame_cnt_q <= '0; probe_colr_q <= '0;
    end else begin
      line_start_q  <= hfall;
      frame_start_q <= vfall;
      sum_valid_q   <= 1'b0;
      probe_valid_q <= 1'b0;
      fmt_err_q     <= 1'b0;
      x_q           <= x_d;
      y_q           <= y_d;
      if (vfall) begin
        sum_q      <= '0;
        bad_q      <= 1'b0;
        hit_q      <= 1'b0;
        hit_colr_q <= '0;
        probe_x_q  <= vga.probe_x;
        probe_y_q  <= vga.probe_y;
        // The frame closing in ALIGN started before reset or alignment, so it is never reported.
        if (state_q != ST_ALIGN) begin
          frame_sum_q <= sum_d;
          sum_valid_q <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
          fmt_err_q   <= frame_bad;
          if (hit_d) begin
            probe_colr_q  <= hit_colr_d;
            probe_valid_q <= 1'b1;
          end
        end
        case (state_q)
          ST_ALIGN: begin
            state_q <= ST_SEARCH;
            good_q  <= 1'b0;
          end
          ST_SEARCH: begin
            if (frame_bad) begin
              good_q <= 1'b0;
            end else if (good_q) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              good_q   <= 1'b0;
            end else begin
              good_q <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (frame_bad) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              good_q   <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_ALIGN;
            locked_q <= 1'b0;
            good_q   <= 1'b0;
          end
        endcase
      end else begin
        sum_q      <= sum_d;
        bad_q      <= bad_d;
        hit_q      <= hit_d;
        hit_colr_q <= hit_colr_d;
      end
    end
  end

  assign vga.rx_x            = x_q;
  assign vga.rx_y            = y_q;
  assign vga.line_start      = line_start_q;
  assign vga.frame_start     = frame_start_q;
  assign vga.locked          = locked_q;
  assign vga.fmt_err         = fmt_err_q;
  assign vga.frame_sum       = frame_sum_q;
  assign vga.frame_sum_valid = sum_valid_q;
  assign vga.probe_colr      = probe_colr_q;
  assign vga.probe_valid     = probe_valid_q;
  assign vga.frame_cnt       = frame_cnt_q;

endmodule
